// File: rtl/wddl_pkg.sv
// Shared types and helpers for the WDDL dual-rail encoder front-end.
// Holds the phase enum, the default word width and the rail-complementarity helper.
package wddl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        EVAL = 2'd2
    } wddl_phase_e;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DR_MAX_W       = 64;

    // Per-bit validity of a dual-rail pair: 1 where the rails are complementary.
    function automatic logic [DR_MAX_W-1:0] dr_valid(input logic [DR_MAX_W-1:0] t,
                                                     input logic [DR_MAX_W-1:0] f);
        return t ^ f;
    endfunction

endpackage

// File: rtl/wddl_phase_cnt.sv
// Down-counter with load, decrement and zero flag; times both the precharge
// and the evaluation phase of the WDDL encoder.
module wddl_phase_cnt
    import wddl_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/wddl_dr_encoder.sv
// Single-rail to WDDL dual-rail encoder: precharge/evaluate waves out, sampled response back.
// Optional WDDL_PRECHARGE_CHECK_EN flags a network that fails to discharge during precharge.
module wddl_dr_encoder
    import wddl_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int PRE_CYCLES  = 1,
    parameter int EVAL_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] dr_t,
    output logic [DATA_W-1:0] dr_f,
    output logic              phase_eval,
    input  logic [DATA_W-1:0] res_t,
    input  logic [DATA_W-1:0] res_f,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err
);

    localparam int MAX_CYC = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    wddl_phase_e       state;
    logic [DATA_W-1:0] data_q;
    logic              accept;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic [CNT_W-1:0]  cnt_val;
    logic [DATA_W-1:0] rail_ok;
    logic              rail_err;
    logic              word_err;

    // in_valid/in_ready handshake: a word transfers on a clock edge where both are high.
    assign accept = (state == IDLE) && in_valid && in_ready;

    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = CNT_W'(PRE_CYCLES - 1);
        case (state)
            IDLE: cnt_load = accept;
            PRE: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(EVAL_CYCLES - 1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            EVAL:    cnt_dec = !cnt_zero;
            default: cnt_dec = 1'b0;
        endcase
    end

    wddl_phase_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign rail_ok  = DATA_W'(dr_valid(DR_MAX_W'(res_t), DR_MAX_W'(res_f)));
    assign rail_err = ~&rail_ok;

`ifdef WDDL_PRECHARGE_CHECK_EN
    logic pre_flag;

    // Any rail still high on the last precharge cycle means the network did not discharge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_flag <= 1'b0;
        end else if ((state == EVAL) && cnt_zero) begin
            pre_flag <= 1'b0;
        end else if ((state == PRE) && cnt_zero && (|(res_t | res_f))) begin
            pre_flag <= 1'b1;
        end
    end

    assign word_err = rail_err | pre_flag;
`else
    assign word_err = rail_err;
`endif

    // Rails come straight from flops so the network never sees a glitch or a 1/1 pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            data_q     <= '0;
            in_ready   <= 1'b1;
            dr_t       <= '0;
            dr_f       <= '0;
            phase_eval <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_err    <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_q   <= in_data;
                        in_ready <= 1'b0;
                        state    <= PRE;
                    end
                end
                PRE: begin
                    if (cnt_zero) begin
                        dr_t       <= data_q;
                        dr_f       <= ~data_q;
                        phase_eval <= 1'b1;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    if (cnt_zero) begin
                        dr_t       <= '0;
                        dr_f       <= '0;
                        phase_eval <= 1'b0;
                        in_ready   <= 1'b1;
                        res_valid  <= 1'b1;
                        res_data   <= res_t;
                        res_err    <= word_err;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wddl_dr_encoder.sv
// Self-checking bench for wddl_dr_encoder: vector table, directed corner sequences,
// randomized words against a phase-age reference model, plus a PRE=3/EVAL=1 instance.
module tb_wddl_dr_encoder;
  localparam int W  = 8;
  localparam int P  = 1;
  localparam int E  = 2;
  localparam int P2 = 3;
  localparam int E2 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] in_data = '0, dr_t, dr_f, res_t = '0, res_f = '0, res_data;
  logic         phase_eval, res_valid, res_err;

  logic         b_in_valid = 1'b0, b_in_ready;
  logic [W-1:0] b_in_data = '0, b_dr_t, b_dr_f, b_res_t = '0, b_res_f = '0, b_res_data;
  logic         b_phase_eval, b_res_valid, b_res_err;

  always #5 clk = ~clk;

  wddl_dr_encoder #(.DATA_W(W), .PRE_CYCLES(P), .EVAL_CYCLES(E)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dr_t(dr_t), .dr_f(dr_f), .phase_eval(phase_eval), .res_t(res_t), .res_f(res_f),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err)
  );

  wddl_dr_encoder #(.DATA_W(W), .PRE_CYCLES(P2), .EVAL_CYCLES(E2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .dr_t(b_dr_t), .dr_f(b_dr_f), .phase_eval(b_phase_eval), .res_t(b_res_t), .res_f(b_res_f),
    .res_valid(b_res_valid), .res_data(b_res_data), .res_err(b_res_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic running = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Rails must never both be high, on either instance.
  always @(negedge clk) begin
    if (running && rst_n) begin
      chk("rails_excl", 32'(dr_t & dr_f), 32'(0));
      chk("rails_excl_b", 32'(b_dr_t & b_dr_f), 32'(0));
    end
  end

  // Reference model: age = cycles since acceptance (0 = idle/ready).
  int           m_age = 0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_res_data = '0;
  logic         m_res_err = 1'b0;
  logic         m_pulse = 1'b0;
  logic         m_pre_flag = 1'b0;

  task automatic model_reset();
    m_age = 0; m_data = '0; m_res_data = '0; m_res_err = 1'b0; m_pulse = 1'b0; m_pre_flag = 1'b0;
  endtask

  task automatic check_model();
    logic         ev;
    logic [W-1:0] et, ef;
    ev = (m_age > P) && (m_age <= P + E);
    et = ev ? m_data : '0;
    ef = ev ? ~m_data : '0;
    chk("in_ready", 32'(in_ready), 32'(m_age == 0));
    chk("phase_eval", 32'(phase_eval), 32'(ev));
    chk("dr_t", 32'(dr_t), 32'(et));
    chk("dr_f", 32'(dr_f), 32'(ef));
    chk("res_valid", 32'(res_valid), 32'(m_pulse));
    chk("res_data", 32'(res_data), 32'(m_res_data));
    chk("res_err", 32'(res_err), 32'(m_res_err));
  endtask

  // Check the current cycle, drive this cycle's inputs, advance the model across the edge.
  task automatic run_cycle(input logic v, input logic [W-1:0] d, input logic [W-1:0] rt,
                           input logic [W-1:0] rf);
    check_model();
    in_valid = v; in_data = d; res_t = rt; res_f = rf;
    m_pulse = 1'b0;
    if (m_age == 0) begin
      if (v) begin
        m_age  = 1;
        m_data = d;
      end
    end else begin
`ifdef WDDL_PRECHARGE_CHECK_EN
      if ((m_age == P) && ((rt | rf) != '0)) m_pre_flag = 1'b1;
`endif
      if (m_age == P + E) begin
        m_res_data = rt;
        m_res_err  = ((rt ^ rf) != 8'hFF) || m_pre_flag;
        m_pre_flag = 1'b0;
        m_pulse    = 1'b1;
        m_age      = 0;
      end else begin
        m_age++;
      end
    end
    tick();
  endtask

  // One word from an idle cycle; returns positioned in its result cycle.
  task automatic do_word(input logic [W-1:0] d, input logic [W-1:0] rt, input logic [W-1:0] rf,
                         input logic [W-1:0] pre_t, input logic [W-1:0] pre_f, input logic hold);
    logic [W-1:0] t, f;
    run_cycle(1'b1, d, '0, '0);
    for (int a = 1; a <= P + E; a++) begin
      t = '0; f = '0;
      if (a == P) begin
        t = pre_t; f = pre_f;
      end else if (a > P) begin
        t = rt; f = rf;
      end
      run_cycle(hold, 8'($urandom), t, f);
    end
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] rt;
    logic [W-1:0] rf;
    logic [W-1:0] exp_data;
    logic         exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int start, pre_cnt, ev_cnt, pulse_at;
    logic [W-1:0] d, rt, rf;

    tbl[0] = '{8'hA5, 8'h3C, 8'hC3, 8'h3C, 1'b0};
    tbl[1] = '{8'hA5, 8'h3C, 8'hC2, 8'h3C, 1'b1};
    tbl[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 1'b0};
    tbl[3] = '{8'hFF, 8'h00, 8'h00, 8'h00, 1'b1};
    tbl[4] = '{8'h5A, 8'h0F, 8'hF0, 8'h0F, 1'b0};
    tbl[5] = '{8'h01, 8'h80, 8'h80, 8'h80, 1'b1};

    // Reset state
    tick();
    tick();
    chk("rst_dr_t", 32'(dr_t), 32'(0));
    chk("rst_dr_f", 32'(dr_f), 32'(0));
    chk("rst_phase_eval", 32'(phase_eval), 32'(0));
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_res_data", 32'(res_data), 32'(0));
    chk("rst_res_err", 32'(res_err), 32'(0));
    rst_n = 1'b1;
    model_reset();
    running = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_b_in_ready", 32'(b_in_ready), 32'(1));

    // Vector table, each word separated by one idle cycle
    for (int i = 0; i < 6; i++) begin
      do_word(tbl[i].d, tbl[i].rt, tbl[i].rf, '0, '0, 1'b0);
      chk("tbl_res_valid", 32'(res_valid), 32'(1));
      chk("tbl_res_data", 32'(res_data), 32'(tbl[i].exp_data));
      chk("tbl_res_err", 32'(res_err), 32'(tbl[i].exp_err));
      chk("tbl_in_ready", 32'(in_ready), 32'(1));
      run_cycle(1'b0, '0, '0, '0);
    end

    // Back-to-back with in_valid held: pulses every P+E+1 cycles
    start = cyc;
    for (int j = 0; j < 3; j++) begin
      do_word(8'(j + 1), 8'(j + 16), ~8'(j + 16), '0, '0, 1'b1);
      chk("b2b_pulse_cycle", 32'(cyc - start), 32'(4 * (j + 1)));
      chk("b2b_res_valid", 32'(res_valid), 32'(1));
    end
    run_cycle(1'b0, '0, '0, '0);

    // Asynchronous reset in the middle of evaluation
    run_cycle(1'b1, 8'hC7, '0, '0);
    run_cycle(1'b0, '0, '0, '0);
    check_model();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_dr_t", 32'(dr_t), 32'(0));
    chk("rst_mid_dr_f", 32'(dr_f), 32'(0));
    chk("rst_mid_phase_eval", 32'(phase_eval), 32'(0));
    tick();
    chk("rst_mid_no_res", 32'(res_valid), 32'(0));
    tick();
    chk("rst_mid_no_res2", 32'(res_valid), 32'(0));
    rst_n = 1'b1;
    model_reset();
    chk("rst_mid_in_ready", 32'(in_ready), 32'(1));
    do_word(8'h6E, 8'h91, 8'h6E, '0, '0, 1'b0);
    chk("after_rst_res_valid", 32'(res_valid), 32'(1));
    chk("after_rst_res_data", 32'(res_data), 32'(8'h91));
    run_cycle(1'b0, '0, '0, '0);

`ifdef WDDL_PRECHARGE_CHECK_EN
    // Undischarged network during the last precharge cycle
    do_word(8'h33, 8'h33, 8'hCC, 8'h00, 8'h01, 1'b0);
    chk("pre_chk_err", 32'(res_err), 32'(1));
    run_cycle(1'b0, '0, '0, '0);
    do_word(8'h44, 8'h44, 8'hBB, 8'h00, 8'h00, 1'b0);
    chk("pre_chk_clean", 32'(res_err), 32'(0));
    run_cycle(1'b0, '0, '0, '0);
`endif

    // Randomized words against the model
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) run_cycle(1'b0, 8'($urandom), '0, '0);
      d  = 8'($urandom);
      rt = 8'($urandom);
      rf = ($urandom_range(0, 1) == 1) ? ~rt : 8'($urandom);
      do_word(d, rt, rf, '0, '0, 1'($urandom_range(0, 1)));
    end
    run_cycle(1'b0, '0, '0, '0);

    // PRE_CYCLES=3, EVAL_CYCLES=1 instance
    pre_cnt = 0; ev_cnt = 0; pulse_at = -1;
    b_in_valid = 1'b1; b_in_data = 8'h96;
    for (int c = 1; c <= 6; c++) begin
      tick();
      b_in_valid = 1'b0;
      b_in_data = 8'($urandom);
      if (!b_in_ready && !b_phase_eval) pre_cnt++;
      if (b_phase_eval) ev_cnt++;
      if (b_res_valid) pulse_at = c;
      chk("sweep_dr_t", 32'(b_dr_t), (c == 4) ? 32'(8'h96) : 32'(0));
      chk("sweep_dr_f", 32'(b_dr_f), (c == 4) ? 32'(8'h69) : 32'(0));
      if (c == 4) begin
        b_res_t = 8'h77; b_res_f = 8'h88;
      end else begin
        b_res_t = '0; b_res_f = '0;
      end
      if (c == 5) begin
        chk("sweep_res_data", 32'(b_res_data), 32'(8'h77));
        chk("sweep_res_err", 32'(b_res_err), 32'(0));
      end
    end
    chk("sweep_pre_len", 32'(pre_cnt), 32'(P2));
    chk("sweep_eval_len", 32'(ev_cnt), 32'(E2));
    chk("sweep_pulse_cycle", 32'(pulse_at), 32'(P2 + E2 + 1));

    running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
